// File: rtl/axe_axi_txn_limiter.sv
// rtl/axe_axi_txn_limiter.sv - outstanding AXI transaction limiter with block/drain gate
// Payloads pass through untouched; only AW/AR valid/ready are gated by count and i_block.
module axe_axi_txn_limiter #(
    parameter int unsigned MaxWrTxns = 8,
    parameter int unsigned MaxRdTxns = 8,
    parameter type axi_aw_t = logic,
    parameter type axi_w_t  = logic,
    parameter type axi_b_t  = logic,
    parameter type axi_ar_t = logic,
    parameter type axi_r_t  = struct packed { logic [31:0] data; logic last; },
    localparam int unsigned WrCntW = $clog2(MaxWrTxns + 1),
    localparam int unsigned RdCntW = $clog2(MaxRdTxns + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  axi_aw_t           i_axi_s_aw,
    input  logic              i_axi_s_aw_valid,
    output logic              o_axi_s_aw_ready,
    input  axi_w_t            i_axi_s_w,
    input  logic              i_axi_s_w_valid,
    output logic              o_axi_s_w_ready,
    input  axi_ar_t           i_axi_s_ar,
    input  logic              i_axi_s_ar_valid,
    output logic              o_axi_s_ar_ready,
    output axi_b_t            o_axi_s_b,
    output logic              o_axi_s_b_valid,
    input  logic              i_axi_s_b_ready,
    output axi_r_t            o_axi_s_r,
    output logic              o_axi_s_r_valid,
    input  logic              i_axi_s_r_ready,
    output axi_aw_t           o_axi_m_aw,
    output logic              o_axi_m_aw_valid,
    input  logic              i_axi_m_aw_ready,
    output axi_w_t            o_axi_m_w,
    output logic              o_axi_m_w_valid,
    input  logic              i_axi_m_w_ready,
    output axi_ar_t           o_axi_m_ar,
    output logic              o_axi_m_ar_valid,
    input  logic              i_axi_m_ar_ready,
    input  axi_b_t            i_axi_m_b,
    input  logic              i_axi_m_b_valid,
    output logic              o_axi_m_b_ready,
    input  axi_r_t            i_axi_m_r,
    input  logic              i_axi_m_r_valid,
    output logic              o_axi_m_r_ready,
    input  logic              i_block,
    output logic              o_idle,
    output logic [WrCntW-1:0] o_wr_outstanding,
    output logic [RdCntW-1:0] o_rd_outstanding,
    output logic              o_err_underflow,
    input  logic              i_err_clear
);

    logic [WrCntW-1:0] wr_cnt_q, wr_cnt_d;
    logic [RdCntW-1:0] rd_cnt_q, rd_cnt_d;
    logic              err_q, err_d;
    logic              wr_full, rd_full;
    logic              aw_hs, b_hs, ar_hs, r_last_hs;
    logic              wr_unf, rd_unf;

    assign wr_full = (wr_cnt_q == WrCntW'(MaxWrTxns));
    assign rd_full = (rd_cnt_q == RdCntW'(MaxRdTxns));

    assign o_axi_m_aw       = i_axi_s_aw;
    assign o_axi_m_aw_valid = i_axi_s_aw_valid & ~wr_full & ~i_block;
    assign o_axi_s_aw_ready = i_axi_m_aw_ready & ~wr_full & ~i_block;
    assign o_axi_m_ar       = i_axi_s_ar;
    assign o_axi_m_ar_valid = i_axi_s_ar_valid & ~rd_full & ~i_block;
    assign o_axi_s_ar_ready = i_axi_m_ar_ready & ~rd_full & ~i_block;

    // W is deliberately ungated so W-before-AW ordering stays legal.
    assign o_axi_m_w       = i_axi_s_w;
    assign o_axi_m_w_valid = i_axi_s_w_valid;
    assign o_axi_s_w_ready = i_axi_m_w_ready;
    assign o_axi_s_b       = i_axi_m_b;
    assign o_axi_s_b_valid = i_axi_m_b_valid;
    assign o_axi_m_b_ready = i_axi_s_b_ready;
    assign o_axi_s_r       = i_axi_m_r;
    assign o_axi_s_r_valid = i_axi_m_r_valid;
    assign o_axi_m_r_ready = i_axi_s_r_ready;

    assign aw_hs     = o_axi_m_aw_valid & i_axi_m_aw_ready;
    assign b_hs      = i_axi_m_b_valid & o_axi_m_b_ready;
    assign ar_hs     = o_axi_m_ar_valid & i_axi_m_ar_ready;
    // Referencing .last makes a missing last field an elaboration error.
    assign r_last_hs = i_axi_m_r_valid & o_axi_m_r_ready & i_axi_m_r.last;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        wr_unf   = 1'b0;
        rd_unf   = 1'b0;
        if (aw_hs && !b_hs) begin
            wr_cnt_d = wr_cnt_q + WrCntW'(1);
        end else if (b_hs && !aw_hs) begin
            if (wr_cnt_q == '0) wr_unf = 1'b1;
            else                wr_cnt_d = wr_cnt_q - WrCntW'(1);
        end
        if (ar_hs && !r_last_hs) begin
            rd_cnt_d = rd_cnt_q + RdCntW'(1);
        end else if (r_last_hs && !ar_hs) begin
            if (rd_cnt_q == '0) rd_unf = 1'b1;
            else                rd_cnt_d = rd_cnt_q - RdCntW'(1);
        end
        err_d = wr_unf | rd_unf | (err_q & ~i_err_clear);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign o_wr_outstanding = wr_cnt_q;
    assign o_rd_outstanding = rd_cnt_q;
    assign o_err_underflow  = err_q;
    assign o_idle           = i_block & (wr_cnt_q == '0) & (rd_cnt_q == '0);

    a_aw_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_axi_m_aw_valid && !i_axi_m_aw_ready |=> $stable(o_axi_m_aw));
    a_w_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_axi_m_w_valid && !i_axi_m_w_ready |=> $stable(o_axi_m_w));
    a_ar_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_axi_m_ar_valid && !i_axi_m_ar_ready |=> $stable(o_axi_m_ar));
    a_wr_max: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(wr_cnt_q > WrCntW'(MaxWrTxns)));
    a_rd_max: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(rd_cnt_q > RdCntW'(MaxRdTxns)));

endmodule
